// File: rtl/half_adder.sv
// Half adder: one-bit propagate (sum) and generate (carry) from two operands.
module half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b;
  assign carry = a & b;

endmodule

// File: rtl/full_adder_using_half_adder.sv
// One-bit full adder built from two half adders, with a combinational result
// and a valid-qualified registered copy of it.
module full_adder_using_half_adder (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  input  logic cin,
  input  logic in_valid,
  output logic sum,
  output logic cout,
  output logic sum_q,
  output logic cout_q,
  output logic out_valid
);

  logic p;
  logic g1;
  logic g2;

  half_adder u_ha_ab (
    .a     (a),
    .b     (b),
    .sum   (p),
    .carry (g1)
  );

  half_adder u_ha_pc (
    .a     (p),
    .b     (cin),
    .sum   (sum),
    .carry (g2)
  );

  // g1 and g2 are mutually exclusive, so OR never needs to carry two.
  assign cout = g1 | g2;

  // Registered stage holds its last valid result; out_valid tracks in_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q     <= 1'b0;
      cout_q    <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (in_valid) begin
        sum_q  <= sum;
        cout_q <= cout;
      end
      out_valid <= in_valid;
    end
  end

endmodule

// File: tb/tb_full_adder_using_half_adder.sv
// Self-checking bench: combinational vector table plus a scoreboard for the
// registered path, covering reset priority and mid-cycle input changes.
module tb_full_adder_using_half_adder;

  logic clk;
  logic clk_en;
  logic rst;
  logic a;
  logic b;
  logic cin;
  logic in_valid;
  logic sum;
  logic cout;
  logic sum_q;
  logic cout_q;
  logic out_valid;

  int tests_run;
  int tests_failed;

  typedef struct {
    logic a;
    logic b;
    logic cin;
    logic exp_sum;
    logic exp_cout;
  } vec_t;

  typedef struct {
    logic sq;
    logic cq;
    logic ov;
  } reg_exp_t;

  vec_t     vecs[8];
  reg_exp_t sb[$];

  // Bench-side model of the registered outputs.
  logic m_sq;
  logic m_cq;
  logic m_ov;

  full_adder_using_half_adder dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .in_valid  (in_valid),
    .sum       (sum),
    .cout      (cout),
    .sum_q     (sum_q),
    .cout_q    (cout_q),
    .out_valid (out_valid)
  );

  initial begin
    clk = 1'b0;
    forever begin
      #5;
      if (clk_en) clk = ~clk;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %b required %b", nm, act, exp);
    end
  endtask

  // Drive one clocked transaction, push its expected registered result, then
  // pop and compare just after the edge.
  task automatic cycle(input logic ia, input logic ib, input logic ic, input logic iv,
                       input logic ir, input string nm);
    int t;
    reg_exp_t e;
    @(negedge clk);
    a = ia; b = ib; cin = ic; in_valid = iv; rst = ir;
    if (ir) begin
      m_sq = 1'b0; m_cq = 1'b0; m_ov = 1'b0;
    end else begin
      if (iv) begin
        t = int'(ia) + int'(ib) + int'(ic);
        m_sq = t[0];
        m_cq = t[1];
      end
      m_ov = iv;
    end
    sb.push_back('{sq: m_sq, cq: m_cq, ov: m_ov});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({nm, "_sb_empty"}, 4'd1, 4'd0);
    end else begin
      e = sb.pop_front();
      chk(nm, {1'b0, sum_q, cout_q, out_valid}, {1'b0, e.sq, e.cq, e.ov});
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    clk_en   = 1'b0;
    rst      = 1'b1;
    a        = 1'b0;
    b        = 1'b0;
    cin      = 1'b0;
    in_valid = 1'b0;
    m_sq = 1'b0; m_cq = 1'b0; m_ov = 1'b0;

    vecs[0] = '{a: 0, b: 0, cin: 0, exp_sum: 0, exp_cout: 0};
    vecs[1] = '{a: 0, b: 0, cin: 1, exp_sum: 1, exp_cout: 0};
    vecs[2] = '{a: 0, b: 1, cin: 0, exp_sum: 1, exp_cout: 0};
    vecs[3] = '{a: 0, b: 1, cin: 1, exp_sum: 0, exp_cout: 1};
    vecs[4] = '{a: 1, b: 0, cin: 0, exp_sum: 1, exp_cout: 0};
    vecs[5] = '{a: 1, b: 0, cin: 1, exp_sum: 0, exp_cout: 1};
    vecs[6] = '{a: 1, b: 1, cin: 0, exp_sum: 0, exp_cout: 1};
    vecs[7] = '{a: 1, b: 1, cin: 1, exp_sum: 1, exp_cout: 1};

    // Combinational path under reset with the clock stopped.
    for (int i = 0; i < 8; i++) begin
      if (i == 0 || i == 3 || i == 5 || i == 6 || i == 7) begin
        a = vecs[i].a; b = vecs[i].b; cin = vecs[i].cin;
        #10;
        chk($sformatf("comb_rst_%0d", i), {2'b00, cout, sum},
            {2'b00, vecs[i].exp_cout, vecs[i].exp_sum});
      end
    end

    clk_en = 1'b1;
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, "reset_state");

    // Exhaustive table: combinational result, generate exclusivity, and the
    // registered copy via the scoreboard.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rst = 1'b0;
      a = vecs[i].a; b = vecs[i].b; cin = vecs[i].cin;
      #1;
      chk($sformatf("comb_%0d", i), {2'b00, cout, sum},
          {2'b00, vecs[i].exp_cout, vecs[i].exp_sum});
      chk($sformatf("g1_and_g2_%0d", i), {3'b000, dut.g1 & dut.g2}, 4'b0000);
      cycle(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b1, 1'b0, $sformatf("reg_%0d", i));
    end

    // Load then drop in_valid: value holds, out_valid falls.
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "load_100");
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "hold_100");
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "hold_ignore_inputs");

    // Reset wins over in_valid; combinational outputs unaffected by rst.
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, "rst_priority");
    chk("rst_comb_111", {2'b00, cout, sum}, 4'b0011);

    // Mid-cycle change of a.
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "load_110");
    #2;
    a = 1'b0;
    #1;
    chk("mid_comb", {2'b00, cout, sum}, 4'b0001);
    chk("mid_reg_unchanged", {2'b00, sum_q, cout_q}, 4'b0001);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "mid_hold");
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "mid_load_010");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/full_adder_using_half_adder.md
FULL_ADDER_USING_HALF_ADDER -- requirements
Module: full_adder_using_half_adder

Interface
REQ-001 The module SHALL have no parameters; all data paths are 1 bit.
REQ-002 The module SHALL have port clk, input, 1 bit: single clock; all sequential logic samples on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The module SHALL have port a, input, 1 bit: addend A.
REQ-005 The module SHALL have port b, input, 1 bit: addend B.
REQ-006 The module SHALL have port cin, input, 1 bit: carry in.
REQ-007 The module SHALL have port in_valid, input, 1 bit: qualifies a/b/cin for the registered path.
REQ-008 The module SHALL have port sum, output, 1 bit: combinational sum bit.
REQ-009 The module SHALL have port cout, output, 1 bit: combinational carry out.
REQ-010 The module SHALL have port sum_q, output, 1 bit: registered sum.
REQ-011 The module SHALL have port cout_q, output, 1 bit: registered carry out.
REQ-012 The module SHALL have port out_valid, output, 1 bit: sum_q/cout_q hold a result captured from a valid input.

Function
REQ-013 sum SHALL equal a XOR b XOR cin, combinationally, with zero latency and independent of clk, rst and in_valid.
REQ-014 cout SHALL equal (a AND b) OR (cin AND (a XOR b)), combinationally.
REQ-015 {cout,sum} SHALL equal the 2-bit arithmetic value a+b+cin for all 8 input combinations; there is no overflow case.
REQ-016 First half adder: inputs a,b; outputs p = a XOR b and g1 = a AND b.
REQ-017 Second half adder: inputs p,cin; sum = p XOR cin and g2 = p AND cin; cout = g1 OR g2.
REQ-018 On a rising clk with rst=0 and in_valid=1, sum_q/cout_q SHALL load sum/cout and out_valid SHALL be 1 on the next cycle (latency 1).
REQ-019 On a rising clk with rst=0 and in_valid=0, sum_q/cout_q SHALL hold their value and out_valid SHALL go 0.
REQ-020 Input changes between clock edges SHALL affect only sum/cout, not the registered outputs.

Reset
REQ-021 On a rising clk with rst=1, sum_q, cout_q and out_valid SHALL all be 0 on the next cycle, regardless of in_valid.
REQ-022 rst SHALL take priority over in_valid when both are 1 on the same edge.
REQ-023 rst SHALL NOT affect the combinational outputs sum and cout.
REQ-024 Output values before the first reset edge are undefined; the bench SHALL apply reset first.

Structure
REQ-025 One sub-module, half_adder (ports a, b, sum, carry), SHALL be instantiated exactly twice.
REQ-026 The top module SHALL add only the final OR gate and the output register stage.
REQ-027 No shared package is required; no typedefs or constants are used.

Verification
REQ-028 Test combinational path with rst=1, no clock edges: a,b,cin = 000, 011, 101, 110, 111, 10 ns apart -> sum,cout = 0/0, 0/1, 0/1, 0/1, 1/1.
REQ-029 Exhaustive test: all 8 input combinations -> {cout,sum} == a+b+cin; also probe g1 and g2 to confirm g1 AND g2 is never 1.
REQ-030 Registered path: a=1,b=0,cin=0, in_valid=1 for one edge -> next cycle sum_q=1, cout_q=0, out_valid=1; then drop in_valid -> out_valid=0 and sum_q stays 1.
REQ-031 Reset priority: rst=1 and in_valid=1 with a=b=cin=1 -> sum_q=0, cout_q=0, out_valid=0; while rst=1 the combinational outputs still read sum=1, cout=1.
REQ-032 Mid-cycle change: change a between edges -> sum/cout follow immediately, while sum_q/cout_q change only at the next valid edge.
